// File: rtl/mem_io_responder.sv
// Bus target for the core: 256-byte RAM, debug register page and TX FIFO.
// Ports: clk, rst (async low), addr/wdata/rd/wr in; rdata, bus_err, dbg_data/dbg_valid out; dbg_ready in.
module mem_io_responder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [12:0] RAM_BASE   = 13'h1800,
    parameter logic [12:0] IO_BASE    = 13'h1F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [7:0]  rdata,
    output logic        bus_err,
    output logic [7:0]  dbg_data,
    output logic        dbg_valid,
    input  logic        dbg_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    ram  [256];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic [7:0]    scratch;
    logic [7:0]    cycle;
    logic          ovf;

    logic          is_ram;
    logic          is_io;
    logic          rd_only;
    logic          wr_only;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          st_rd;
    logic [7:0]    io_rdata;

    assign is_ram  = addr[12:8] == RAM_BASE[12:8];
    assign is_io   = addr[12:2] == IO_BASE[12:2];
    assign rd_only = rd & ~wr;
    assign wr_only = wr & ~rd;
    assign full    = count == CW'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign push    = wr_only & is_io & (addr[1:0] == 2'd0);
    assign pop     = ~empty & dbg_ready;
    assign st_rd   = rd_only & is_io & (addr[1:0] == 2'd1);

    assign dbg_valid = ~empty;
    assign dbg_data  = fifo[rptr];

    always_comb begin
        io_rdata = 8'h00;
        unique case (addr[1:0])
            2'd0: io_rdata = 8'h00;
            2'd1: io_rdata = {5'b0, ovf, full, empty};
            2'd2: io_rdata = scratch;
            2'd3: io_rdata = cycle;
        endcase
    end

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_only && is_ram)
            ram[addr[7:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata   <= 8'h00;
            bus_err <= 1'b0;
            scratch <= 8'h00;
            cycle   <= 8'h00;
            ovf     <= 1'b0;
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo[i] <= 8'h00;
        end else begin
            cycle   <= cycle + 8'd1;
            bus_err <= (rd & wr) | ((rd ^ wr) & ~(is_ram | is_io));

            if (rd_only) begin
                if (is_ram)
                    rdata <= ram[addr[7:0]];
                else if (is_io)
                    rdata <= io_rdata;
                else
                    rdata <= 8'h00;
            end

            if (wr_only && is_io && addr[1:0] == 2'd2)
                scratch <= wdata;

            // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
            if (push && (!full || pop)) begin
                fifo[wptr] <= wdata;
                wptr       <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);

            if (push && (!full || pop) && !pop)
                count <= count + CW'(1);
            else if (pop && !(push && (!full || pop)))
                count <= count - CW'(1);

            // Overflow set wins over the clear-on-read.
            if (push && full && !pop)
                ovf <= 1'b1;
            else if (st_rd)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed scenarios plus random traffic.
// Compares DUT against a queue/array based behavioural model.
module tb_mem_io_responder;

    localparam int          DEPTH = 4;
    localparam logic [12:0] RAMB  = 13'h1800;
    localparam logic [12:0] IOB   = 13'h1F00;

    logic        clk = 0;
    logic        rst = 0;
    logic [12:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        rd = 0;
    logic        wr = 0;
    logic [7:0]  rdata;
    logic        bus_err;
    logic [7:0]  dbg_data;
    logic        dbg_valid;
    logic        dbg_ready = 0;

    int vec = 0;
    int errs = 0;

    logic [7:0] mram [256];
    bit         mramv [256];
    logic [7:0] mscr;
    logic [7:0] mq [$];
    bit         movf;
    logic [7:0] mcyc;
    logic [7:0] erd;
    bit         erdv;
    bit         eerr;

    mem_io_responder #(.FIFO_DEPTH(DEPTH), .RAM_BASE(RAMB), .IO_BASE(IOB)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
        .rdata(rdata), .bus_err(bus_err), .dbg_data(dbg_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        movf = 0;
        mscr = 8'h00;
        mcyc = 8'h00;
        erd  = 8'h00;
        erdv = 1;
        eerr = 0;
    endtask

    // Drive one bus cycle, advance the model, return #1 after the edge.
    task automatic step(input logic r, input logic w, input logic [12:0] a,
                        input logic [7:0] d, input logic rdy);
        bit ram_s, io_s, push, pop;
        logic [7:0] rv;
        rd = r; wr = w; addr = a; wdata = d; dbg_ready = rdy;
        ram_s = a[12:8] == RAMB[12:8];
        io_s  = a[12:2] == IOB[12:2];
        pop   = mq.size() > 0 && rdy;
        push  = w && !r && io_s && a[1:0] == 2'd0;
        eerr  = (r && w) || ((r != w) && !(ram_s || io_s));
        if (r && !w) begin
            rv = 8'h00;
            erdv = 1;
            if (ram_s) begin
                rv = mram[a[7:0]];
                erdv = mramv[a[7:0]];
            end else if (io_s) begin
                case (a[1:0])
                    2'd1: rv = {5'b0, movf, mq.size() == DEPTH, mq.size() == 0};
                    2'd2: rv = mscr;
                    2'd3: rv = mcyc;
                    default: rv = 8'h00;
                endcase
            end
            erd = rv;
        end
        if (w && !r && ram_s) begin
            mram[a[7:0]] = d;
            mramv[a[7:0]] = 1;
        end
        if (w && !r && io_s && a[1:0] == 2'd2) mscr = d;
        if (r && !w && io_s && a[1:0] == 2'd1) movf = 0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else movf = 1;
        end
        mcyc = mcyc + 8'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(0, 0, 13'h0000, 8'h00, rdy);
    endtask

    task automatic do_reset();
        #2;
        rst = 0;
        rd = 0; wr = 0; dbg_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (rdata !== 8'h00) begin errs++; $display("FAIL reset_rdata got %h want 00", rdata); end
        vec++; if (bus_err !== 1'b0) begin errs++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
        vec++; if (dbg_valid !== 1'b0) begin errs++; $display("FAIL reset_dbg_valid got %b want 0", dbg_valid); end
        vec++; if (dbg_data !== 8'h00) begin errs++; $display("FAIL reset_dbg_data got %h want 00", dbg_data); end
    endtask

    task automatic test_ram();
        step(0, 1, 13'h1800, 8'hA5, 0);
        vec++; if (bus_err !== 0) begin errs++; $display("FAIL ram_wr0_err got %b want 0", bus_err); end
        step(0, 1, 13'h18FF, 8'h3C, 0);
        vec++; if (bus_err !== 0) begin errs++; $display("FAIL ram_wr1_err got %b want 0", bus_err); end
        step(1, 0, 13'h1800, 8'h00, 0);
        vec++; if (rdata !== 8'hA5) begin errs++; $display("FAIL ram_rd0 got %h want a5", rdata); end
        vec++; if (bus_err !== 0) begin errs++; $display("FAIL ram_rd0_err got %b want 0", bus_err); end
        step(1, 0, 13'h18FF, 8'h00, 0);
        vec++; if (rdata !== 8'h3C) begin errs++; $display("FAIL ram_rd1 got %h want 3c", rdata); end
        vec++; if (bus_err !== 0) begin errs++; $display("FAIL ram_rd1_err got %b want 0", bus_err); end
    endtask

    task automatic test_unmapped();
        step(1, 0, 13'h0100, 8'h00, 0);
        vec++; if (rdata !== 8'h00) begin errs++; $display("FAIL unm_rd got %h want 00", rdata); end
        vec++; if (bus_err !== 1) begin errs++; $display("FAIL unm_rd_err got %b want 1", bus_err); end
        idle(0);
        vec++; if (bus_err !== 0) begin errs++; $display("FAIL unm_pulse_len got %b want 0", bus_err); end
        step(0, 1, 13'h1F10, 8'hEE, 0);
        vec++; if (bus_err !== 1) begin errs++; $display("FAIL unm_wr_err got %b want 1", bus_err); end
        step(1, 0, 13'h1F02, 8'h00, 0);
        vec++; if (rdata !== 8'h00) begin errs++; $display("FAIL unm_scratch got %h want 00", rdata); end
        step(1, 0, 13'h1800, 8'h00, 0);
        vec++; if (rdata !== 8'hA5) begin errs++; $display("FAIL unm_ram got %h want a5", rdata); end
    endtask

    task automatic test_fifo_ovf();
        logic [7:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 13'h1F00, 8'h11 * 8'(i + 1), 0);
            vec++; if (bus_err !== 0) begin errs++; $display("FAIL ovf_push%0d_err got %b want 0", i, bus_err); end
        end
        step(1, 0, 13'h1F01, 8'h00, 0);
        vec++; if (rdata !== 8'h06) begin errs++; $display("FAIL ovf_status1 got %h want 06", rdata); end
        step(1, 0, 13'h1F01, 8'h00, 0);
        vec++; if (rdata !== 8'h02) begin errs++; $display("FAIL ovf_status2 got %h want 02", rdata); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (dbg_valid !== 1 || dbg_data !== seq[i]) begin
                errs++; $display("FAIL ovf_drain%0d got %b/%h want 1/%h", i, dbg_valid, dbg_data, seq[i]);
            end
            idle(1);
        end
        vec++; if (dbg_valid !== 0) begin errs++; $display("FAIL ovf_empty got %b want 0", dbg_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] seq [4];
        seq[0] = 8'h02; seq[1] = 8'h03; seq[2] = 8'h04; seq[3] = 8'h66;
        for (int i = 1; i <= 4; i++) step(0, 1, 13'h1F00, 8'(i), 0);
        step(0, 1, 13'h1F00, 8'h66, 1);
        step(1, 0, 13'h1F01, 8'h00, 0);
        vec++; if (rdata !== 8'h02) begin errs++; $display("FAIL pp_status got %h want 02", rdata); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (dbg_valid !== 1 || dbg_data !== seq[i]) begin
                errs++; $display("FAIL pp_drain%0d got %b/%h want 1/%h", i, dbg_valid, dbg_data, seq[i]);
            end
            idle(1);
        end
        vec++; if (dbg_valid !== 0) begin errs++; $display("FAIL pp_empty got %b want 0", dbg_valid); end
    endtask

    task automatic test_cycle_both();
        step(1, 0, 13'h1F03, 8'h00, 0);
        vec++; if (rdata !== erd) begin errs++; $display("FAIL cyc_rd0 got %h want %h", rdata, erd); end
        repeat (255) idle(0);
        step(1, 0, 13'h1F03, 8'h00, 0);
        vec++; if (rdata !== erd) begin errs++; $display("FAIL cyc_rd256 got %h want %h", rdata, erd); end
        step(0, 1, 13'h1F02, 8'h5A, 0);
        step(1, 0, 13'h1F02, 8'h00, 0);
        vec++; if (rdata !== 8'h5A) begin errs++; $display("FAIL scr_rd got %h want 5a", rdata); end
        step(1, 1, 13'h1F02, 8'hFF, 0);
        vec++; if (bus_err !== 1 || rdata !== 8'h5A) begin
            errs++; $display("FAIL both_hi got %b/%h want 1/5a", bus_err, rdata);
        end
        idle(0);
        vec++; if (bus_err !== 0) begin errs++; $display("FAIL both_pulse got %b want 0", bus_err); end
        step(1, 0, 13'h1F02, 8'h00, 0);
        vec++; if (rdata !== 8'h5A) begin errs++; $display("FAIL both_scr got %h want 5a", rdata); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 13'h1F00, 8'hC0 + 8'(i), 0);
        idle(1);
        vec++; if (dbg_valid !== 1 || dbg_data !== 8'hC1) begin
            errs++; $display("FAIL ar_pre got %b/%h want 1/c1", dbg_valid, dbg_data);
        end
        #2;
        rst = 0;
        #1;
        vec++; if (dbg_valid !== 0) begin errs++; $display("FAIL ar_async got %b want 0", dbg_valid); end
        rd = 0; wr = 0; dbg_ready = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        step(1, 0, 13'h1F03, 8'h00, 0);
        vec++; if (rdata !== 8'h00) begin errs++; $display("FAIL ar_cycle got %h want 00", rdata); end
        step(1, 0, 13'h1F01, 8'h00, 0);
        vec++; if (rdata !== 8'h01) begin errs++; $display("FAIL ar_status got %h want 01", rdata); end
    endtask

    task automatic test_random();
        logic [12:0] a;
        logic r, w, rdy;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: a = RAMB + 13'($urandom_range(0, 15));
                1, 2: a = IOB + 13'($urandom_range(0, 3));
                default: a = 13'($urandom_range(0, 8191));
            endcase
            r = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 1) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            step(r, w, a, 8'($urandom), rdy);
            vec++; if (bus_err !== eerr) begin
                errs++; $display("FAIL rnd%0d_err got %b want %b", n, bus_err, eerr);
            end
            if (erdv) begin
                vec++; if (rdata !== erd) begin
                    errs++; $display("FAIL rnd%0d_rdata got %h want %h", n, rdata, erd);
                end
            end
            vec++; if (dbg_valid !== (mq.size() != 0)) begin
                errs++; $display("FAIL rnd%0d_valid got %b want %b", n, dbg_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                vec++; if (dbg_data !== mq[0]) begin
                    errs++; $display("FAIL rnd%0d_data got %h want %h", n, dbg_data, mq[0]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mramv[i] = 0;
        test_reset();
        test_ram();
        test_unmapped();
        test_fifo_ovf();
        test_full_push_pop();
        test_cycle_both();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
